// File: rtl/floor_tracker_pkg.sv
// Shared constants for the floor tracker and the stepper driver controller:
// floor one-hot codes, coil phase sequence, direction encoding and FSM states.
package floor_tracker_pkg;

    localparam logic [3:0] FLOOR_G = 4'b0001;
    localparam logic [3:0] FLOOR_1 = 4'b0010;
    localparam logic [3:0] FLOOR_2 = 4'b0100;
    localparam logic [3:0] FLOOR_3 = 4'b1000;

    localparam logic [3:0] PH_A = 4'b0001;
    localparam logic [3:0] PH_B = 4'b0010;
    localparam logic [3:0] PH_C = 4'b0100;
    localparam logic [3:0] PH_D = 4'b1000;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_STEP = 1'b1
    } state_e;

    // Upward successor of a coil pattern; non-one-hot patterns have none.
    function automatic logic [3:0] phase_next(input logic [3:0] p);
        logic [3:0] r;
        case (p)
            PH_A:    r = PH_B;
            PH_B:    r = PH_C;
            PH_C:    r = PH_D;
            PH_D:    r = PH_A;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] phase_prev(input logic [3:0] p);
        logic [3:0] r;
        case (p)
            PH_A:    r = PH_D;
            PH_B:    r = PH_A;
            PH_C:    r = PH_B;
            PH_D:    r = PH_C;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // Floor zone shifts saturate at the shaft ends.
    function automatic logic [3:0] floor_up(input logic [3:0] f);
        logic [3:0] r;
        case (f)
            FLOOR_G: r = FLOOR_1;
            FLOOR_1: r = FLOOR_2;
            FLOOR_2: r = FLOOR_3;
            FLOOR_3: r = FLOOR_3;
            default: r = FLOOR_G;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] floor_dn(input logic [3:0] f);
        logic [3:0] r;
        case (f)
            FLOOR_G: r = FLOOR_G;
            FLOOR_1: r = FLOOR_G;
            FLOOR_2: r = FLOOR_1;
            FLOOR_3: r = FLOOR_2;
            default: r = FLOOR_G;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/floor_tracker_if.sv
// Bus between the motor-driver side (master) and the floor tracker (slave).
interface floor_tracker_if;

    logic [3:0] phase;
    logic [3:0] des;
    logic       fault_clr;
    logic [3:0] cs;
    logic       at_floor;
    logic       arrived;
    logic       moving;
    logic       dir;
    logic       fault;

    modport master (
        output phase, des, fault_clr,
        input  cs, at_floor, arrived, moving, dir, fault
    );

    modport slave (
        input  phase, des, fault_clr,
        output cs, at_floor, arrived, moving, dir, fault
    );

endinterface

// File: rtl/floor_tracker_phase_step_decoder.sv
// Classifies each coil pattern against the last non-zero one as an up step,
// down step, or protocol violation; keeps that last pattern in prev_q.
module phase_step_decoder
    import floor_tracker_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] phase_i,
    output logic       step_up_o,
    output logic       step_dn_o,
    output logic       bad_o
);

    logic [3:0] prev_q;
    logic [3:0] prev_d;

    // Step classification; a driver-off (0000) or repeated pattern is no step.
    always_comb begin
        step_up_o = 1'b0;
        step_dn_o = 1'b0;
        bad_o     = 1'b0;
        prev_d    = prev_q;
        if ((phase_i == 4'b0000) || (phase_i == prev_q)) begin
            prev_d = prev_q;
        end else begin
            prev_d = phase_i;
            if (phase_i == phase_next(prev_q)) begin
                step_up_o = 1'b1;
            end else if (phase_i == phase_prev(prev_q)) begin
                step_dn_o = 1'b1;
            end else begin
                bad_o = 1'b1;
            end
        end
    end

    // Last non-zero coil pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= PH_A;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/floor_tracker.sv
// Elevator car position tracker driven by stepper coil phases.
// Optional stall fault between floors: define FLOOR_TRACKER_STALL_DETECT_EN.
module floor_tracker
    import floor_tracker_pkg::*;
#(
    parameter int STEPS_PER_FLOOR = 512,
    parameter int IDLE_CYCLES     = 1024,
    parameter int STALL_CYCLES    = 65536
) (
    input  logic            clk,
    input  logic            rst_n,
    floor_tracker_if.slave  bus
);

    localparam int CW = $clog2(STEPS_PER_FLOOR);
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
    localparam logic [CW-1:0] CNT_TOP   = CW'(STEPS_PER_FLOOR - 1);
    localparam logic [IW-1:0] IDLE_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] IDLE_ONE  = IW'(32'd1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);

    state_e        state_q, state_d;
    logic [3:0]    cs_q, cs_d;
    logic [CW-1:0] step_cnt_q, step_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          dir_q, dir_d;
    logic          arrived_q, arrived_d;
    logic          fault_q, fault_d;

    logic step_up_s, step_dn_s, bad_s;
    logic at_floor_s, lim_up_s, lim_dn_s, valid_s, stall_evt_s;

    phase_step_decoder u_dec (
        .clk       (clk),
        .rst_n     (rst_n),
        .phase_i   (bus.phase),
        .step_up_o (step_up_s),
        .step_dn_o (step_dn_s),
        .bad_o     (bad_s)
    );

    assign at_floor_s = (step_cnt_q == CNT_ZERO);

    // Position update; a step past either shaft end is refused and held.
    always_comb begin
        cs_d       = cs_q;
        step_cnt_d = step_cnt_q;
        dir_d      = dir_q;
        lim_up_s   = step_up_s && at_floor_s && (cs_q == FLOOR_3);
        lim_dn_s   = step_dn_s && at_floor_s && (cs_q == FLOOR_G);
        valid_s    = (step_up_s && !lim_up_s) || (step_dn_s && !lim_dn_s);
        if (step_up_s && !lim_up_s) begin
            dir_d = DIR_UP;
            if (step_cnt_q == CNT_TOP) begin
                step_cnt_d = CNT_ZERO;
                cs_d       = floor_up(cs_q);
            end else begin
                step_cnt_d = step_cnt_q + CNT_ONE;
            end
        end else if (step_dn_s && !lim_dn_s) begin
            dir_d = DIR_DN;
            if (step_cnt_q == CNT_ZERO) begin
                step_cnt_d = CNT_TOP;
                cs_d       = floor_dn(cs_q);
            end else begin
                step_cnt_d = step_cnt_q - CNT_ONE;
            end
        end else begin
            cs_d       = cs_q;
            step_cnt_d = step_cnt_q;
        end
    end

`ifdef FLOOR_TRACKER_STALL_DETECT_EN
    localparam int SW = $clog2(STALL_CYCLES + 1);
    localparam logic [SW-1:0] STALL_ZERO = {SW{1'b0}};
    localparam logic [SW-1:0] STALL_ONE  = SW'(32'd1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYCLES - 1);
    localparam logic [SW-1:0] STALL_FULL = SW'(STALL_CYCLES);

    logic [SW-1:0] stall_cnt_q, stall_cnt_d;

    // Counts stepless cycles between floors; saturates so the event fires once.
    always_comb begin
        stall_evt_s = 1'b0;
        stall_cnt_d = stall_cnt_q;
        if (valid_s || at_floor_s) begin
            stall_cnt_d = STALL_ZERO;
        end else if (stall_cnt_q != STALL_FULL) begin
            stall_cnt_d = stall_cnt_q + STALL_ONE;
            stall_evt_s = (stall_cnt_q == STALL_LAST);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= STALL_ZERO;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    assign stall_evt_s = 1'b0;
`endif

    // Arrival pulse and sticky fault; a new fault event outranks fault_clr.
    always_comb begin
        arrived_d = valid_s && (step_cnt_d == CNT_ZERO) && (cs_d == bus.des) && !arrived_q;
        if (bad_s || lim_up_s || lim_dn_s || stall_evt_s) begin
            fault_d = 1'b1;
        end else if (bus.fault_clr) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end
    end

    // Motion FSM: any valid step keeps it in STEP and restarts the idle count.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            ST_IDLE: begin
                idle_cnt_d = IDLE_ZERO;
                if (valid_s) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (valid_s) begin
                    idle_cnt_d = IDLE_ZERO;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = ST_IDLE;
                    idle_cnt_d = IDLE_ZERO;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_ONE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                idle_cnt_d = IDLE_ZERO;
            end
        endcase
    end

    // State registers; reset re-homes the car to ground level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cs_q       <= FLOOR_G;
            step_cnt_q <= CNT_ZERO;
            idle_cnt_q <= IDLE_ZERO;
            dir_q      <= DIR_DN;
            arrived_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            step_cnt_q <= step_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            dir_q      <= dir_d;
            arrived_q  <= arrived_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.cs       = cs_q;
    assign bus.at_floor = at_floor_s;
    assign bus.arrived  = arrived_q;
    assign bus.moving   = (state_q == ST_STEP);
    assign bus.dir      = dir_q;
    assign bus.fault    = fault_q;

endmodule

// File: tb/tb_floor_tracker.sv
// Directed table-driven bench for floor_tracker with 4 steps per floor,
// 8 idle cycles and 16 stall cycles.
module tb_floor_tracker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    floor_tracker_if bus ();

    floor_tracker #(
        .STEPS_PER_FLOOR (4),
        .IDLE_CYCLES     (8),
        .STALL_CYCLES    (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef FLOOR_TRACKER_STALL_DETECT_EN
    localparam logic EXP_STALL = 1'b1;
`else
    localparam logic EXP_STALL = 1'b0;
`endif

    typedef struct {
        logic [3:0] ph;
        logic [3:0] ds;
        logic       clr;
        logic [3:0] cs;
        logic       af;
        logic       ar;
        logic       mv;
        logic       dr;
        logic       ft;
    } vec_t;

    vec_t tbl [26];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ph, input logic [3:0] ds, input logic clr);
        @(negedge clk);
        bus.phase     = ph;
        bus.des       = ds;
        bus.fault_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] cs, input logic af,
                             input logic ar, input logic mv, input logic dr, input logic ft);
        chk({tag, ".cs"},       bus.cs, cs);
        chk({tag, ".at_floor"}, {3'b000, bus.at_floor}, {3'b000, af});
        chk({tag, ".arrived"},  {3'b000, bus.arrived},  {3'b000, ar});
        chk({tag, ".moving"},   {3'b000, bus.moving},   {3'b000, mv});
        chk({tag, ".dir"},      {3'b000, bus.dir},      {3'b000, dr});
        chk({tag, ".fault"},    {3'b000, bus.fault},    {3'b000, ft});
    endtask

    initial begin
        logic [3:0] ph;

        //           phase    des      clr   cs       af    ar    mv    dir   fault
        tbl[0]  = '{4'b0010, 4'b0100, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{4'b0100, 4'b0100, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{4'b1000, 4'b0100, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{4'b0001, 4'b0100, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{4'b0010, 4'b0100, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{4'b0100, 4'b0100, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{4'b1000, 4'b0100, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{4'b0001, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{4'b0001, 4'b0010, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{4'b0001, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{4'b1000, 4'b0100, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{4'b0100, 4'b0100, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{4'b0010, 4'b0100, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{4'b0001, 4'b0100, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{4'b1000, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{4'b0100, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{4'b0010, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{4'b0100, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[19] = '{4'b0110, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[20] = '{4'b0110, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[21] = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[22] = '{4'b1000, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[23] = '{4'b1000, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[24] = '{4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[25] = '{4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        bus.phase     = 4'b0001;
        bus.des       = 4'b0100;
        bus.fault_clr = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].ph, tbl[i].ds, tbl[i].clr);
            check_all($sformatf("vec%0d", i), tbl[i].cs, tbl[i].af, tbl[i].ar,
                      tbl[i].mv, tbl[i].dr, tbl[i].ft);
        end

        // One up step, then hold the phase: moving drops on the 8th idle cycle.
        drive(4'b0001, 4'b0001, 1'b0);
        check_all("hold_step", 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            drive(4'b0001, 4'b0001, 1'b0);
            chk($sformatf("hold%0d.moving", i), {3'b000, bus.moving},
                {3'b000, (i < 8) ? 1'b1 : 1'b0});
            if (i == 15) chk("hold15.fault", {3'b000, bus.fault}, 4'b0000);
            if (i == 16) chk("hold16.fault", {3'b000, bus.fault}, {3'b000, EXP_STALL});
        end

        // Climb to cs=0100 with step_cnt=2, then assert reset between edges.
        ph = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            ph = {ph[2:0], ph[3]};
            drive(ph, 4'b0001, 1'b0);
        end
        chk("mid.cs", bus.cs, 4'b0100);
        chk("mid.at_floor", {3'b000, bus.at_floor}, 4'b0000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.phase = 4'b0001;
        @(negedge clk);
        rst_n = 1'b1;

        // Full climb to the top floor, then an up step into the limit.
        ph = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            ph = {ph[2:0], ph[3]};
            drive(ph, 4'b1000, 1'b0);
        end
        check_all("top", 4'b1000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(4'b0010, 4'b1000, 1'b0);
        check_all("top_limit", 4'b1000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/floor_tracker.md
FLOOR_TRACKER -- requirements
Module: floor_tracker

Interface
REQ-001 Parameter STEPS_PER_FLOOR, default 512, full motor steps between adjacent floors (power of two, 4..4096).
REQ-002 Parameter IDLE_CYCLES, default 1024, clk cycles without a step before the motion indication drops.
REQ-003 Parameter STALL_CYCLES, default 65536, clk cycles without a step between floors before a stall fault.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 phase  input  4  stepper coil pattern from the motor driver, same clock domain.
REQ-007 des  input  4  one-hot destination floor.
REQ-008 fault_clr  input  1  single-cycle clear of the sticky fault.
REQ-009 cs  output  4  one-hot current floor zone (0001 ground .. 1000 top).
REQ-010 at_floor  output  1  car exactly level with floor cs.
REQ-011 arrived  output  1  one-cycle pulse on landing level at des.
REQ-012 moving  output  1  motor stepping recently.
REQ-013 dir  output  1  last valid step direction, 1 = up.
REQ-014 fault  output  1  sticky protocol/limit/stall fault.

Function
REQ-015 Up sequence SHALL be 0001->0010->0100->1000->0001; down is the reverse.
REQ-016 Register previous non-zero phase (prev); each cycle compare phase with prev: successor = up step, predecessor = down step, equal or 0000 = no step (driver off, no fault).
REQ-017 Any other non-zero phase (non-one-hot or two-position skip) SHALL set fault, cause no step, and update prev.
REQ-018 Position = (cs, step_cnt), step_cnt in 0..STEPS_PER_FLOOR-1; at_floor = (step_cnt == 0), combinational from registers.
REQ-019 Up step: step_cnt+1; at STEPS_PER_FLOOR-1 wrap to 0 and shift cs left one position.
REQ-020 Down step: at step_cnt 0 set step_cnt to STEPS_PER_FLOOR-1 and shift cs right; else step_cnt-1.
REQ-021 Up step at cs=1000 with step_cnt 0, or down step at cs=0001 with step_cnt 0, SHALL set fault and hold position.
REQ-022 Every valid step updates dir, sets moving, reloads idle counter; moving clears after IDLE_CYCLES consecutive no-step cycles.
REQ-023 arrived SHALL pulse the cycle after a step that leaves step_cnt 0 with cs == des; latency one clk; never two consecutive cycles.
REQ-024 des change while at_floor and cs == des SHALL NOT generate arrived.
REQ-025 fault clears only on fault_clr; fault_clr coincident with a new fault event leaves fault set.
REQ-026 State machine: IDLE (moving=0), STEP (moving=1); IDLE->STEP on valid step, STEP->IDLE on idle counter expiry; faults do not change state.

Reset
REQ-027 rst_n low SHALL immediately force cs=0001, step_cnt=0, prev=0001, dir=0, moving=0, arrived=0, fault=0, counters 0, state IDLE.
REQ-028 Reset mid-travel discards position; car is re-homed to ground by reset only.

Configuration
REQ-029 Macro FLOOR_TRACKER_STALL_DETECT_EN: when defined, moving=1 with at_floor=0 and STALL_CYCLES cycles without a step SHALL set fault; when undefined no stall counter exists and stalls between floors only drop moving.

Structure
REQ-030 Shared package holds floor one-hot constants (FLOOR_G, FLOOR_1, FLOOR_2, FLOOR_3), phase sequence constants, and up/down direction encoding, shared with the driver controller.
REQ-031 One sub-module, phase_step_decoder: phase/prev in, step_up/step_dn/bad out, purely combinational plus prev register.

Verification (STEPS_PER_FLOOR=4, IDLE_CYCLES=8, STALL_CYCLES=16)
REQ-032 Reset, des=0100, feed 8 up phases -> cs 0001->0010->0100, arrived one pulse after 8th step, at_floor=1, dir=1.
REQ-033 From cs=0100 at floor, one down phase -> cs=0010, step_cnt=3, at_floor=0, dir=0, no arrived.
REQ-034 At cs=0001 level, down phase 0001->1000 -> fault=1, cs=0001; fault_clr -> fault=0.
REQ-035 phase 0001->0100 skip, then 0110 -> fault=1, position unchanged, prev tracks.
REQ-036 One up step then phase held 9 cycles -> moving drops after cycle 8; with FLOOR_TRACKER_STALL_DETECT_EN hold 16 cycles -> fault=1.
REQ-037 rst_n low mid-floor (cs=0100, step_cnt=2) -> all outputs at reset values same cycle, asynchronously.
